i2c_reg_bridge: RTL

//  Register-file back end for the I2C slave byte engine. Consumes its address, rx-byte, tx-done and

---
 rtl/i2c_reg_bridge.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/i2c_reg_bridge.sv
// Register-file back end for the I2C slave byte engine: pointer byte, auto-incrementing
// register writes and reads, with a stall window so the tx byte settles before release.
module i2c_reg_bridge #(
  parameter logic [6:0] I2C_ADDRESS = 7'h42,
  parameter int         NUM_REGS    = 8,
  parameter int         PTR_W       = 3,
  parameter int         STALL_CYC   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            i2c_addr_rw,
  input  logic                  i2c_addr_rw_valid_stb,
  input  logic [7:0]            i2c_data_rx,
  input  logic                  i2c_data_rx_valid_stb,
  input  logic                  i2c_data_tx_done_stb,
  input  logic                  i2c_error_stb,
  output logic [7:0]            i2c_data_tx,
  output logic                  stall,
  output logic [8*NUM_REGS-1:0] reg_q,
  output logic                  reg_wr_stb,
  output logic [PTR_W-1:0]      reg_wr_addr
);

  typedef enum logic [1:0] {ST_IDLE, ST_PTR, ST_WRITE, ST_READ} state_t;

  state_t           state_r;
  logic [PTR_W-1:0] ptr_r;
  logic             ptr_ok_r;
  logic [7:0]       regs_r [NUM_REGS];
  logic [3:0]       stall_cnt_r;

  logic             addr_hit_s;
  logic             addr_acc_s;
  logic             rx_acc_s;
  logic             tx_acc_s;
  logic             any_acc_s;
  logic             rx_in_range_s;
  logic [PTR_W-1:0] ptr_inc_s;

  // Strobe qualification: error beats everything, address beats data/tx_done.
  always_comb begin
    addr_hit_s    = 1'b0;
    addr_acc_s    = 1'b0;
    rx_acc_s      = 1'b0;
    tx_acc_s      = 1'b0;
    any_acc_s     = 1'b0;
    rx_in_range_s = 1'b0;
    ptr_inc_s     = '0;
    addr_hit_s    = (i2c_addr_rw[7:1] == I2C_ADDRESS);
    addr_acc_s    = i2c_addr_rw_valid_stb & addr_hit_s & ~i2c_error_stb;
    if ((state_r == ST_PTR) || (state_r == ST_WRITE)) begin
      rx_acc_s = i2c_data_rx_valid_stb & ~i2c_addr_rw_valid_stb & ~i2c_error_stb;
    end else begin
      rx_acc_s = 1'b0;
    end
    if (state_r == ST_READ) begin
      tx_acc_s = i2c_data_tx_done_stb & ~i2c_addr_rw_valid_stb & ~i2c_error_stb;
    end else begin
      tx_acc_s = 1'b0;
    end
    any_acc_s     = addr_acc_s | rx_acc_s | tx_acc_s;
    rx_in_range_s = ({1'b0, i2c_data_rx} < 9'(NUM_REGS));
    if (ptr_r == PTR_W'(NUM_REGS - 1)) begin
      ptr_inc_s = '0;
    end else begin
      ptr_inc_s = ptr_r + PTR_W'(1);
    end
  end

  // Transaction FSM, register storage and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      ptr_r       <= '0;
      ptr_ok_r    <= 1'b1;
      stall_cnt_r <= 4'd0;
      stall       <= 1'b0;
      i2c_data_tx <= 8'h00;
      reg_wr_stb  <= 1'b0;
      reg_wr_addr <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= 8'h00;
      end
    end else begin
      reg_wr_stb  <= 1'b0;
      i2c_data_tx <= ptr_ok_r ? regs_r[ptr_r] : 8'hFF;

      // Reload on every accepted strobe so the window always covers the latest tx update.
      if (any_acc_s) begin
        stall       <= 1'b1;
        stall_cnt_r <= 4'(STALL_CYC - 1);
      end else if (stall_cnt_r != 4'd0) begin
        stall_cnt_r <= stall_cnt_r - 4'd1;
      end else begin
        stall       <= 1'b0;
      end

      if (i2c_error_stb) begin
        state_r <= ST_IDLE;
      end else if (i2c_addr_rw_valid_stb) begin
        if (!addr_hit_s) begin
          state_r <= ST_IDLE;
        end else if (i2c_addr_rw[0]) begin
          state_r <= ST_READ;
        end else begin
          state_r <= ST_PTR;
        end
      end else if (rx_acc_s) begin
        case (state_r)
          ST_PTR: begin
            ptr_r    <= i2c_data_rx[PTR_W-1:0];
            ptr_ok_r <= rx_in_range_s;
            state_r  <= ST_WRITE;
          end
          ST_WRITE: begin
            if (ptr_ok_r) begin
              regs_r[ptr_r] <= i2c_data_rx;
              reg_wr_stb    <= 1'b1;
              reg_wr_addr   <= ptr_r;
              ptr_r         <= ptr_inc_s;
            end else begin
              ptr_r         <= ptr_r;
            end
          end
          default: begin
            state_r <= state_r;
          end
        endcase
      end else if (tx_acc_s) begin
        if (ptr_ok_r) begin
          ptr_r <= ptr_inc_s;
        end else begin
          ptr_r <= ptr_r;
        end
      end else begin
        state_r <= state_r;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
    assign reg_q[8*g +: 8] = regs_r[g];
  end

endmodule
